// File: rtl/uart_defs_pkg.sv
// uart_defs: shared constants, FSM state encoding and helpers for the UART
// receive monitor and its FIFO.
// Optional parity support in the receiver is enabled by defining UART_RX_PARITY_EN.
package uart_defs;

  localparam int DATA_W           = 8;
  localparam int CLKS_PER_BIT_DEF = 868;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } rx_state_e;

  // Even parity: the transmitted parity bit equals the XOR of the data bits.
  function automatic logic even_par(input logic [DATA_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with wrap-bit pointers. A push into a full
// FIFO is accepted only when a pop frees the head slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  pop,
  output logic [WIDTH-1:0]      rdata,
  output logic                  full,
  output logic                  empty,
  output logic                  push_ok,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

  logic [DEPTH_LOG2:0] wr_ptr_q;
  logic [DEPTH_LOG2:0] rd_ptr_q;
  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic                pop_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                   (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign count   = wr_ptr_q - rd_ptr_q;
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

  // Pointer update; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_rx_monitor.sv
// uart_rx_monitor: 8N1 UART receiver feeding a byte FIFO with a valid/ready
// output stream and sticky frame/overflow error flags.
// Define UART_RX_PARITY_EN for 8E1 reception with a sticky parity_err output.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | line idle, waiting for synced falling edge
// START      | half-bit wait, then confirm start bit (high = glitch)
// DATA       | sample 8 data bits LSB-first, one per bit period
// PARITY     | sample even-parity bit (UART_RX_PARITY_EN only)
// STOP       | sample stop bit; high pushes the byte, low is a framing error
// WAIT_IDLE  | line held low after a bad stop bit, wait for it to go high
module uart_rx_monitor
  import uart_defs::*;
#(
  parameter int CLKS_PER_BIT    = CLKS_PER_BIT_DEF,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rx_in,
  output logic [DATA_W-1:0]          dout,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic [FIFO_DEPTH_LOG2:0]   fifo_count,
  output logic                       busy,
  output logic                       frame_err,
  output logic                       overflow,
`ifdef UART_RX_PARITY_EN
  output logic                       parity_err,
`endif
  input  logic                       err_clr
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
  // The IDLE cycle that detects the low level already counts toward the
  // half-bit, so the start-bit sample lands CLKS_PER_BIT/2 cycles after the
  // synced falling edge. This is why CLKS_PER_BIT must be at least 4.
  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLKS_PER_BIT / 2 - 2);
  localparam logic [2:0] LAST_BIT = 3'(DATA_W - 1);

  logic              sync1_q;
  logic              rx_s_q;
  rx_state_e         state_q;
  logic [CNT_W-1:0]  baud_q;
  logic [2:0]        bit_q;
  logic [DATA_W-1:0] shreg_q;
  logic              frame_err_q, frame_err_d;
  logic              overflow_q,  overflow_d;
`ifdef UART_RX_PARITY_EN
  logic              par_bad_q;
  logic              parity_err_q, parity_err_d;
  logic              par_set;
`endif

  logic baud_tc;
  logic stop_sample;
  logic push;
  logic push_ok;
  logic fifo_full;
  logic fifo_empty;

  // Two-flop synchroniser for the asynchronous serial line, idle high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= rx_in;
      rx_s_q  <= sync1_q;
    end
  end

  assign baud_tc     = (baud_q == '0);
  assign stop_sample = (state_q == ST_STOP) && baud_tc;
`ifdef UART_RX_PARITY_EN
  assign push        = stop_sample && rx_s_q && !par_bad_q;
  assign par_set     = (state_q == ST_PARITY) && baud_tc &&
                       (rx_s_q != even_par(shreg_q));
`else
  assign push        = stop_sample && rx_s_q;
`endif

  // Receive FSM with down-counting baud timer and bit counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!rx_s_q) begin
            state_q <= ST_START;
            baud_q  <= HALF_RELOAD;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
`endif
          end
        end
        ST_START: begin
          if (baud_tc) begin
            if (rx_s_q) begin
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_DATA;
              baud_q  <= BIT_RELOAD;
              bit_q   <= '0;
            end
          end else begin
            baud_q <= baud_q - CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (baud_tc) begin
            shreg_q <= {rx_s_q, shreg_q[DATA_W-1:1]};
            baud_q  <= BIT_RELOAD;
            if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_q <= ST_PARITY;
`else
              state_q <= ST_STOP;
`endif
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end else begin
            baud_q <= baud_q - CNT_W'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (baud_tc) begin
            par_bad_q <= (rx_s_q != even_par(shreg_q));
            baud_q    <= BIT_RELOAD;
            state_q   <= ST_STOP;
          end else begin
            baud_q <= baud_q - CNT_W'(1);
          end
        end
`endif
        ST_STOP: begin
          if (baud_tc) begin
            state_q <= rx_s_q ? ST_IDLE : ST_WAIT_IDLE;
          end else begin
            baud_q <= baud_q - CNT_W'(1);
          end
        end
        ST_WAIT_IDLE: begin
          if (rx_s_q) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Sticky flag next-state: a set event in the same cycle as err_clr wins.
  always_comb begin
    frame_err_d = (stop_sample && !rx_s_q) || (frame_err_q && !err_clr);
    overflow_d  = (push && !push_ok)       || (overflow_q  && !err_clr);
`ifdef UART_RX_PARITY_EN
    parity_err_d = par_set || (parity_err_q && !err_clr);
`endif
  end

  // Sticky flag registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  sync_fifo #(
    .WIDTH      (DATA_W),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wdata   (shreg_q),
    .pop     (dout_ready),
    .rdata   (dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .push_ok (push_ok),
    .count   (fifo_count)
  );

  assign dout_valid = !fifo_empty;
  assign busy       = (state_q != ST_IDLE);
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

  // fifo_full is already folded into push_ok; kept visible for debug.
  logic unused_full;
  assign unused_full = fifo_full;

endmodule
